keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 25 ++
 rtl/keypad_col_timer.sv | 38 +++
 rtl/keypad_scanner.sv | 144 ++++++++++++++
 tb/tb_keypad_scanner.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;
    localparam int CODE_W   = 4;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Rows are active-low; the lowest-numbered low row wins.
    function automatic logic [1:0] lowest_low_row(input logic [NUM_ROWS-1:0] rows_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!rows_n[r]) idx = 2'(r);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_col_timer.sv
// Column period divider: strobes o_sample on the last cycle of each column
// period and steps the column there unless i_hold is asserted.
module keypad_col_timer
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1024
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_hold,
    output logic [1:0] o_col,
    output logic       o_sample
);

    localparam int DW = $clog2(SCAN_DIV);

    logic [DW-1:0] r_div;
    logic [1:0]    r_col;

    assign o_sample = (r_div == DW'(SCAN_DIV - 1));
    assign o_col    = r_col;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div <= '0;
            r_col <= 2'd0;
        end else begin
            if (o_sample) r_div <= '0;
            else          r_div <= r_div + DW'(1);

            if (o_sample && !i_hold) begin
                if (r_col == 2'(NUM_COLS - 1)) r_col <= 2'd0;
                else                           r_col <= r_col + 2'd1;
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, debounced press/release, one-cycle
// key_valid pulse with row*4+col code.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1024,
    parameter int DEBOUNCE = 8
) (
    input  logic              CLK,
    input  logic              RST,
    output logic [3:0]        col_out,
    input  logic [3:0]        row_in,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    output logic              key_down,
    output state_t            o_dbg_state
);

    localparam int            CW       = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE);

    logic [3:0]        r_sync1, r_sync2;
    state_t            r_state;
    logic [CW-1:0]     r_count;
    logic [1:0]        r_row;
    logic              r_key_valid;
    logic [CODE_W-1:0] r_key_code;
    logic              r_key_down;

    logic [1:0]    w_col;
    logic          w_sample;
    state_t        w_next_state;
    logic [CW-1:0] w_count_next;
    logic [1:0]    w_row_next;
    logic [CW-1:0] w_count_inc;
    logic          w_count_done;
    logic          w_any_low;
    logic          w_cap_low;
    logic          w_accept;
    logic          w_release_done;
    logic          w_advance;

    keypad_col_timer #(.SCAN_DIV(SCAN_DIV)) u_col_timer (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_hold   (!w_advance),
        .o_col    (w_col),
        .o_sample (w_sample)
    );

    assign w_any_low    = (r_sync2 != 4'hF);
    assign w_cap_low    = !r_sync2[r_row];
    assign w_count_inc  = r_count + CW'(1);
    assign w_count_done = (w_count_inc == DEB_LAST);

    // State register, synchronizer and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1     <= 4'hF;
            r_sync2     <= 4'hF;
            r_state     <= ST_SCAN;
            r_count     <= '0;
            r_row       <= 2'd0;
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
            r_key_down  <= 1'b0;
        end else begin
            r_sync1     <= row_in;
            r_sync2     <= r_sync1;
            r_state     <= w_next_state;
            r_count     <= w_count_next;
            r_row       <= w_row_next;
            r_key_valid <= w_accept;
            if (w_accept)            r_key_code <= {w_row_next, w_col};
            if (w_accept)            r_key_down <= 1'b1;
            else if (w_release_done) r_key_down <= 1'b0;
        end
    end

    // Next-state logic; every decision is taken only at the sample point.
    always_comb begin
        w_next_state = r_state;
        w_count_next = r_count;
        w_row_next   = r_row;
        if (w_sample) begin
            case (r_state)
                ST_SCAN: begin
                    if (w_any_low) begin
                        w_row_next   = lowest_low_row(r_sync2);
                        w_count_next = CW'(1);
                        if (DEBOUNCE == 1) w_next_state = ST_HELD;
                        else               w_next_state = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!w_cap_low) begin
                        w_next_state = ST_SCAN;
                        w_count_next = '0;
                    end else begin
                        w_count_next = w_count_inc;
                        if (w_count_done) w_next_state = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (!w_cap_low) begin
                        w_count_next = CW'(1);
                        if (DEBOUNCE == 1) w_next_state = ST_SCAN;
                        else               w_next_state = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (w_cap_low) begin
                        w_next_state = ST_HELD;
                    end else begin
                        w_count_next = w_count_inc;
                        if (w_count_done) w_next_state = ST_SCAN;
                    end
                end
                default: w_next_state = ST_SCAN;
            endcase
        end
    end

    // Output decode: press accept, release complete, column advance.
    always_comb begin
        w_accept       = 1'b0;
        w_release_done = 1'b0;
        w_advance      = 1'b0;
        if (w_sample) begin
            w_accept       = (w_next_state == ST_HELD) &&
                             (r_state == ST_SCAN || r_state == ST_DEBOUNCE);
            w_release_done = (w_next_state == ST_SCAN) &&
                             (r_state == ST_HELD || r_state == ST_RELEASE);
            w_advance      = (w_next_state == ST_SCAN);
        end
    end

    assign col_out     = ~(4'b0001 << w_col);
    assign key_valid   = r_key_valid;
    assign key_code    = r_key_code;
    assign key_down    = r_key_down;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulated key matrix, sample-period-level
// reference model, directed scenarios followed by random key activity.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  col_out;
    logic [3:0]  row_in;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_down;
    keypad_pkg::state_t dbg_state;

    logic [15:0] key_mask = '0;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEB)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .col_out     (col_out),
        .row_in      (row_in),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_down    (key_down),
        .o_dbg_state (dbg_state)
    );

    always #5 CLK = ~CLK;

    // Physical matrix: a pressed key pulls its row low when its column is driven.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_mask[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    // Reference model, one update per sample period.
    int         m_col, m_row, m_run;
    bit         m_down, m_pulse;
    logic [3:0] m_code;
    logic [3:0] exp_q[$];

    int n_pass   = 0;
    int n_checks = 0;
    int n_pulses = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_col = 0; m_row = 0; m_run = 0;
        m_down = 0; m_pulse = 0; m_code = 4'd0;
        exp_q.delete();
    endtask

    task automatic model_sample(input logic [15:0] mask);
        bit pressed[4];
        int found;
        for (int r = 0; r < 4; r++) pressed[r] = mask[r*4+m_col];
        m_pulse = 0;
        if (!m_down) begin
            if (m_run == 0) begin
                found = -1;
                for (int r = 0; r < 4; r++) if (pressed[r] && found < 0) found = r;
                if (found >= 0) begin
                    m_row = found;
                    m_run = 1;
                end else begin
                    m_col = (m_col + 1) % 4;
                end
            end else if (pressed[m_row]) begin
                m_run++;
            end else begin
                m_run = 0;
                m_col = (m_col + 1) % 4;
            end
            if (m_run == DEB) begin
                m_down  = 1;
                m_pulse = 1;
                m_code  = 4'(m_row * 4 + m_col);
                m_run   = 0;
                exp_q.push_back(m_code);
            end
        end else begin
            if (!pressed[m_row]) m_run++;
            else                 m_run = 0;
            if (m_run == DEB) begin
                m_down = 0;
                m_run  = 0;
                m_col  = (m_col + 1) % 4;
            end
        end
    endtask

    // One column period; entered and left #1 after the edge that starts it.
    task automatic run_period(input logic [15:0] mask, input int rst_at);
        logic [3:0] exp_col;
        key_mask = mask;
        exp_col  = ~(4'b0001 << m_col);
        for (int k = 0; k < SCAN_DIV; k++) begin
            check("col_out", col_out, exp_col);
            check("key_valid", key_valid, (k == 0) && m_pulse);
            check("key_down", key_down, m_down);
            check("key_code", key_code, m_code);
            if (key_valid) begin
                n_pulses++;
                check("valid_queued", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("valid_code", key_code, exp_q.pop_front());
            end
            if (k == rst_at) begin
                RST = 1'b1;
                @(posedge CLK); #1;
                RST = 1'b0;
                key_mask = '0;
                model_reset();
                return;
            end
            @(posedge CLK); #1;
        end
        model_sample(mask);
    endtask

    initial begin
        int p0;
        logic [15:0] cur;
        int hold;

        model_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        check("rst_col_out", col_out, 4'b1110);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_down", key_down, 0);
        check("rst_key_code", key_code, 0);
        check("rst_state", dbg_state, keypad_pkg::ST_SCAN);

        // Idle scan through all columns and wrap.
        repeat (5) run_period(16'h0000, -1);

        // Row 2 / column 1 press, then release with a one-sample glitch.
        p0 = n_pulses;
        repeat (6) run_period(16'h0200, -1);
        check("held_code", key_code, 4'd9);
        check("held_down", key_down, 1);
        check("held_col_out", col_out, 4'b1101);
        repeat (2) run_period(16'h0000, -1);
        run_period(16'h0200, -1);
        check("glitch_down", key_down, 1);
        repeat (3) run_period(16'h0000, -1);
        check("released_down", key_down, 0);
        check("press_pulses", n_pulses - p0, 1);

        // Single-sample bounce on row 0 / column 3.
        for (int g = 0; g < 8 && m_col != 3; g++) run_period(16'h0000, -1);
        p0 = n_pulses;
        run_period(16'h0008, -1);
        run_period(16'h0000, -1);
        check("bounce_col_out", col_out, 4'b1110);
        run_period(16'h0000, -1);
        check("bounce_pulses", n_pulses - p0, 0);

        // Rows 1 and 3 in column 0, then a column-2 key while held.
        for (int g = 0; g < 8 && m_col != 0; g++) run_period(16'h0000, -1);
        p0 = n_pulses;
        repeat (4) run_period(16'h1010, -1);
        repeat (4) run_period(16'h1014, -1);
        check("multi_code", key_code, 4'd4);
        check("multi_pulses", n_pulses - p0, 1);
        repeat (4) run_period(16'h0000, -1);

        // Reset pulse while debouncing row 1 / column 1.
        for (int g = 0; g < 8 && m_col != 1; g++) run_period(16'h0000, -1);
        p0 = n_pulses;
        run_period(16'h0020, -1);
        run_period(16'h0020, 1);
        check("dbrst_col_out", col_out, 4'b1110);
        check("dbrst_key_down", key_down, 0);
        repeat (4) run_period(16'h0000, -1);
        check("dbrst_pulses", n_pulses - p0, 0);

        // Random key activity with occasional resets.
        cur  = '0;
        hold = 0;
        for (int i = 0; i < 150; i++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 3))
                    0:       cur = '0;
                    1, 2:    cur = 16'h0001 << $urandom_range(0, 15);
                    default: cur = (16'h0001 << $urandom_range(0, 15)) |
                                   (16'h0001 << $urandom_range(0, 15));
                endcase
                hold = $urandom_range(1, 6);
            end
            hold--;
            if ($urandom_range(0, 59) == 0) run_period(cur, $urandom_range(0, 3));
            else                            run_period(cur, -1);
        end
        repeat (8) run_period(16'h0000, -1);
        check("exp_q_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
